// File: rtl/ps2_kbd_rx_fifo.sv
`timescale 1ns/1ps
// ps2_kbd_rx_fifo
// PS/2 keyboard receiver with prefix folding and a first-word-fall-through
// event FIFO. The PS/2 lines are synchronised and glitch-filtered. 11-bit
// frames are deserialised, and their odd parity and stop bit are checked.
// E0/F0 prefixes are folded into the next scan code, and the resulting events
// are queued for a valid/ready consumer.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   ps2_clk, ps2_data raw PS/2 lines (asynchronous to clk)
//   evt_valid/ready   FIFO head handshake; pop on evt_valid & evt_ready
//   evt_code/break/ext head event fields (zero while the FIFO is empty)
//   fifo_count        number of queued events
//   overflow          sticky dropped-event flag, cleared by clr_flags
//   parity_err        one-cycle pulse on parity mismatch
//   frame_err         one-cycle pulse on bad stop bit or mid-frame timeout
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for a start bit (data low on a strobe)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | latching the parity check result
// S_STOP   | checking the stop bit, accepting or rejecting the byte
module ps2_kbd_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_break,
    output logic                          evt_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err,
    input  logic                          clr_flags
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FILT_ONE  = FW'(1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    CODE_EXT  = 8'hE0;
    localparam logic [7:0]    CODE_BRK  = 8'hF0;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk, filt_clk_d;
    logic          strobe;

    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          parity_ok;
    logic          ext_pend, brk_pend;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          push_req;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [9:0]    head;
    logic          pop, full, do_push;

    // Lines idle high, so the synchronisers reset to 1 to avoid a fake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Down-counter reloads whenever the sample agrees with the filtered level;
    // reaching zero means FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt   <= FILT_LOAD;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= FILT_LOAD;
            end else if (filt_cnt == '0) begin
                filt_clk <= clk_s2;
                filt_cnt <= FILT_LOAD;
            end else begin
                filt_cnt <= filt_cnt - FILT_ONE;
            end
        end
    end

    assign strobe  = filt_clk_d & ~filt_clk;
    assign tmo_hit = (state != S_IDLE) && (tmo_cnt == '0) && !strobe;

    // A completed non-prefix byte is pushed on the edge that ends the STOP strobe.
    assign push_req = strobe && (state == S_STOP) && dat_s2 && parity_ok
                      && (shreg != CODE_EXT) && (shreg != CODE_BRK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            parity_ok  <= 1'b0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            tmo_cnt    <= TMO_LOAD;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (strobe || state == S_IDLE)
                tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TMO_ONE;

            if (tmo_hit) begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end else if (strobe) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state  <= S_DATA;
                            bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg  <= {dat_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= S_PARITY;
                    end
                    S_PARITY: begin
                        parity_ok <= ^{shreg, dat_s2};
                        state     <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!dat_s2) begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end else if (!parity_ok) begin
                            parity_err <= 1'b1;
                            ext_pend   <= 1'b0;
                            brk_pend   <= 1'b0;
                        end else if (shreg == CODE_EXT) begin
                            ext_pend <= 1'b1;
                        end else if (shreg == CODE_BRK) begin
                            brk_pend <= 1'b1;
                        end else begin
                            ext_pend <= 1'b0;
                            brk_pend <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // FIFO: a push into a full FIFO is still allowed when the head pops in the same cycle.
    assign pop     = evt_valid && evt_ready;
    assign full    = (fifo_count == CNT_FULL);
    assign do_push = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {ext_pend, brk_pend, shreg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !pop)
                fifo_count <= fifo_count + CNT_ONE;
            else if (pop && !do_push)
                fifo_count <= fifo_count - CNT_ONE;
            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (clr_flags)
                overflow <= 1'b0;
        end
    end

    // Head fields are gated so stale or uninitialised storage never shows when empty.
    assign head      = mem[rd_ptr];
    assign evt_valid = (fifo_count != '0);
    assign evt_code  = evt_valid ? head[7:0] : 8'h00;
    assign evt_break = evt_valid & head[8];
    assign evt_ext   = evt_valid & head[9];

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
`timescale 1ns/1ps
module tb_ps2_kbd_rx_fifo;

    localparam int DEPTH = 16;
    localparam int TMO   = 2000;
    localparam int HP    = 40;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, evt_ready, clr_flags;
    logic       evt_valid, evt_break, evt_ext, overflow, parity_err, frame_err;
    logic [7:0] evt_code;
    logic [4:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stop_cyc, rise_cyc, fall_cyc;
    int pop_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
    bit valid_prev = 1'b0;
    bit ext_m = 1'b0, brk_m = 1'b0;
    bit allow_full_push = 1'b0;
    logic [9:0] exp_q[$];
    event stop_ev;

    ps2_kbd_rx_fifo #(.FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_break(evt_break), .evt_ext(evt_ext), .fifo_count(fifo_count),
        .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err),
        .clr_flags(clr_flags)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard monitor: samples 2 ns after the falling edge, pops on handshake.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            valid_prev = evt_valid;
        end else begin
            if (evt_valid && !valid_prev) rise_cyc = cyc;
            if (!evt_valid && valid_prev) fall_cyc = cyc;
            valid_prev = evt_valid;
            if (parity_err) perr_cnt++;
            if (frame_err) ferr_cnt++;
            if (evt_valid && evt_ready) begin
                pop_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got ext=%0b brk=%0b code=%h, none expected",
                             evt_ext, evt_break, evt_code);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({evt_ext, evt_break, evt_code} !== e) begin
                        failures++;
                        $display("FAIL event got ext=%0b brk=%0b code=%h exp ext=%0b brk=%0b code=%h",
                                 evt_ext, evt_break, evt_code, e[9], e[8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_v);
        logic [10:0] bits;
        bits = {stop_v, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                stop_cyc = cyc;
                if (stop_v && !bad_par) begin
                    if (b == 8'hE0) ext_m = 1'b1;
                    else if (b == 8'hF0) brk_m = 1'b1;
                    else begin
                        if (exp_q.size() < DEPTH || allow_full_push)
                            exp_q.push_back({ext_m, brk_m, b});
                        ext_m = 1'b0;
                        brk_m = 1'b0;
                    end
                end else begin
                    ext_m = 1'b0;
                    brk_m = 1'b0;
                end
                -> stop_ev;
            end
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    // Start bit plus (n-1) data bits, then the lines are left idle-high.
    task automatic send_partial(input int n, output int last_fall);
        logic [10:0] bits;
        bits = {1'b1, 1'b0, 8'h5A, 1'b0};
        last_fall = cyc;
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && fifo_count != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_count !== 5'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain fifo_count=%0d pending_expected=%0d, required 0 and 0",
                     name, fifo_count, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b1; clr_flags = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({evt_valid, fifo_count, overflow, parity_err, frame_err} !== 9'd0) begin
            failures++;
            $display("FAIL reset_status valid=%0b count=%0d ovf=%0b perr=%0b ferr=%0b, required all 0",
                     evt_valid, fifo_count, overflow, parity_err, frame_err);
        end
        checks++;
        if ({evt_code, evt_break, evt_ext} !== 10'd0) begin
            failures++;
            $display("FAIL reset_head code=%h brk=%0b ext=%0b, required 0",
                     evt_code, evt_break, evt_ext);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single;
        int p0, f0, c0;
        p0 = perr_cnt; f0 = ferr_cnt; c0 = pop_cnt;
        rise_cyc = -1; fall_cyc = -1;
        send_good(8'h1C);
        drain("single");
        checks++;
        if (rise_cyc - stop_cyc != 11) begin
            failures++;
            $display("FAIL single_latency valid rose %0d cycles after stop fall, required 11",
                     rise_cyc - stop_cyc);
        end
        checks++;
        if (fall_cyc - rise_cyc != 1) begin
            failures++;
            $display("FAIL single_valid_width valid high %0d cycles, required 1",
                     fall_cyc - rise_cyc);
        end
        checks++;
        if (pop_cnt - c0 != 1 || perr_cnt != p0 || ferr_cnt != f0) begin
            failures++;
            $display("FAIL single_counts events=%0d perr=%0d ferr=%0d, required 1 0 0",
                     pop_cnt - c0, perr_cnt - p0, ferr_cnt - f0);
        end
    endtask

    task automatic test_prefix;
        int c0, e0;
        c0 = pop_cnt; e0 = perr_cnt + ferr_cnt;
        send_good(8'hF0);
        send_good(8'h1C);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        drain("prefix");
        checks++;
        if (pop_cnt - c0 != 2 || perr_cnt + ferr_cnt != e0) begin
            failures++;
            $display("FAIL prefix_counts events=%0d errors=%0d, required 2 0",
                     pop_cnt - c0, perr_cnt + ferr_cnt - e0);
        end
    endtask

    task automatic test_errors;
        int c0, p0, f0;
        c0 = pop_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++;
        if (perr_cnt - p0 != 1 || pop_cnt != c0 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL parity_err perr_cycles=%0d events=%0d count=%0d, required 1 0 0",
                     perr_cnt - p0, pop_cnt - c0, fifo_count);
        end
        send_good(8'hE0);
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++;
        if (ferr_cnt - f0 != 1 || perr_cnt - p0 != 1 || pop_cnt != c0) begin
            failures++;
            $display("FAIL bad_stop ferr_cycles=%0d perr_cycles=%0d events=%0d, required 1 1 0",
                     ferr_cnt - f0, perr_cnt - p0, pop_cnt - c0);
        end
        send_good(8'h75);
        drain("errors");
        checks++;
        if (pop_cnt - c0 != 1) begin
            failures++;
            $display("FAIL errors_recovery events=%0d, required 1", pop_cnt - c0);
        end
    endtask

    task automatic test_overflow;
        evt_ready = 1'b0;
        for (int i = 1; i <= 17; i++) send_good(8'(i));
        checks++;
        if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_full count=%0d ovf=%0b, required 16 1", fifo_count, overflow);
        end
        evt_ready = 1'b1;
        drain("overflow");
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky ovf=%0b, required 1", overflow);
        end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear ovf=%0b, required 0", overflow);
        end
        evt_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_good(8'h20 + 8'(i));
        checks++;
        if (fifo_count !== 5'd16) begin
            failures++;
            $display("FAIL refill count=%0d, required 16", fifo_count);
        end
        allow_full_push = 1'b1;
        fork
            send_good(8'h30);
            begin
                @(stop_ev);
                repeat (10) @(negedge clk);
                evt_ready = 1'b1;
                @(negedge clk);
                evt_ready = 1'b0;
            end
        join
        allow_full_push = 1'b0;
        checks++;
        if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL push_pop_full count=%0d ovf=%0b, required 16 0", fifo_count, overflow);
        end
        evt_ready = 1'b1;
        drain("push_pop");
    endtask

    task automatic test_glitch_timeout;
        int c0, f0, p0, lf, waited;
        c0 = pop_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        ps2_data = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        ps2_data = 1'b1;
        repeat (HP) @(negedge clk);
        send_good(8'h1C);
        drain("glitch");
        checks++;
        if (pop_cnt - c0 != 1 || ferr_cnt != f0 || perr_cnt != p0) begin
            failures++;
            $display("FAIL glitch events=%0d ferr=%0d perr=%0d, required 1 0 0",
                     pop_cnt - c0, ferr_cnt - f0, perr_cnt - p0);
        end
        send_partial(5, lf);
        while (cyc - lf < 1900) @(negedge clk);
        checks++;
        if (ferr_cnt != f0) begin
            failures++;
            $display("FAIL timeout_early frame_err seen %0d cycles after last fall, required none before 1900",
                     cyc - lf);
        end
        waited = 0;
        while (ferr_cnt == f0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (ferr_cnt - f0 != 1) begin
            failures++;
            $display("FAIL timeout frame_err cycles=%0d by %0d cycles after last fall, required 1",
                     ferr_cnt - f0, cyc - lf);
        end
        ext_m = 1'b0; brk_m = 1'b0;
        repeat (10) @(negedge clk);
        send_good(8'h29);
        drain("timeout");
        checks++;
        if (pop_cnt - c0 != 2) begin
            failures++;
            $display("FAIL timeout_recovery events=%0d, required 2", pop_cnt - c0);
        end
    endtask

    task automatic test_reset_mid;
        int c0, lf;
        evt_ready = 1'b0;
        send_good(8'h1C);
        send_good(8'h32);
        send_good(8'h21);
        send_partial(5, lf);
        checks++;
        if (fifo_count !== 5'd3) begin
            failures++;
            $display("FAIL reset_mid_queued count=%0d, required 3", fifo_count);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid valid=%0b count=%0d, required 0 0", evt_valid, fifo_count);
        end
        exp_q.delete();
        ext_m = 1'b0; brk_m = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        evt_ready = 1'b1;
        repeat (5) @(negedge clk);
        c0 = pop_cnt;
        send_good(8'h1C);
        drain("reset_mid");
        checks++;
        if (pop_cnt - c0 != 1) begin
            failures++;
            $display("FAIL reset_mid_recovery events=%0d, required 1", pop_cnt - c0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_errors();
        test_overflow();
        test_glitch_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx_fifo.md
Name: ps2_kbd_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver: a generalised successor to the single-byte keyboard scanner. It runs in the 50 MHz `clk` domain.
- Synchronises and glitch-filters the PS/2 lines, deserialises 11-bit frames, and checks odd parity and the stop bit.
- Folds E0 (extended) and F0 (break) prefixes into one key event.
- Buffers events in a first-word-fall-through FIFO with a valid/ready handshake, so consumers such as the VGA text display never miss keystrokes.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples needed before the filtered ps2_clk changes level
FIFO_DEPTH, 16, event FIFO entries; power of two, >= 2
TIMEOUT_CYCLES, 50000, clk cycles with no bit strobe mid-frame before the frame is aborted (1 ms at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
ps2_clk  in  1  PS/2 clock, asynchronous to clk
ps2_data  in  1  PS/2 data, asynchronous to clk
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts the head event; pop when evt_valid & evt_ready
evt_code  out  8  head event scan code
evt_break  out  1  head event is a key release (F0 prefix seen)
evt_ext  out  1  head event is extended (E0 prefix seen)
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued events
overflow  out  1  sticky: an event was dropped because the FIFO was full
parity_err  out  1  one-cycle pulse: parity mismatch
frame_err  out  1  one-cycle pulse: bad stop bit or timeout
clr_flags  in  1  clears overflow

Behaviour:
- Reset (async, rst=1):
  - Outputs: all outputs 0.
  - Internal state: FSM=IDLE, FIFO empty, filtered clock=1, bit counter, timeout counter and pending prefix flags cleared.
  - Reset mid-frame discards the partial frame and all queued events.
- Input conditioning: 2-flop synchroniser on each line. The filtered clock flips only after FILTER_LEN consecutive synchronised samples differ from it.
- Bit strobe: one-cycle pulse on each 1->0 transition of the filtered clock. Synchronised ps2_data is sampled in that cycle.
- FSM, advancing on strobes only:
  - IDLE: data=0 -> DATA, bitcnt=0. data=1 -> stay in IDLE (spurious start ignored).
  - DATA: shift in LSB-first. After the 8th bit -> PARITY.
  - PARITY: latch parity_ok = XOR(8 data bits, parity bit) == 1. -> STOP.
  - STOP: if stop=0, pulse frame_err (takes precedence over parity). Else if !parity_ok, pulse parity_err. Else the byte is accepted. -> IDLE.
- Timeout: the counter resets on every strobe and while in IDLE. In any other state, reaching TIMEOUT_CYCLES pulses frame_err, discards the byte and returns to IDLE.
- Any error, whether frame, parity or timeout, also clears the pending prefix flags.
- Decoder, on each accepted byte:
  - E0 sets ext_pending.
  - F0 sets brk_pending.
  - Any other byte pushes {ext_pending, brk_pending, byte} and clears both flags.
  - Prefixes never produce events.
- Latency: the push occurs on the clk edge after the STOP strobe cycle. If the FIFO was empty, evt_valid rises in that same next cycle.
- FIFO behaviour:
  - First-word fall-through: the evt_* outputs show the head combinationally from registered storage.
  - evt_valid = (fifo_count != 0).
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO boundary cases:
  - Push when full with no pop in the same cycle: event dropped, overflow set.
  - Push and pop in the same cycle: both performed (allowed when full); count unchanged.
  - Pop when empty: ignored.
- overflow: cleared by clr_flags. If set and clear coincide, set wins.
- evt_ready is ignored while evt_valid=0.

Test Plan (clk=20 ns, FILTER_LEN=8, TIMEOUT_CYCLES=2000, PS/2 half-period 40 clk, evt_ready=1 unless stated):
1. Frame 0x1C, parity 0, stop 1 -> single event code=1C, break=0, ext=0; evt_valid high 1 cycle after STOP strobe, low 1 cycle after pop; no error pulses.
2. Byte sequences:
   - F0,1C -> single event code=1C, break=1.
   - E0,F0,75 -> single event code=75, break=1, ext=1; no events for the prefixes.
3. Error recovery:
   - 0x1C sent with parity=1 -> one-cycle parity_err, no event.
   - Then E0, then a bad-stop frame -> frame_err; the following 0x75 gives ext=0 (prefix cleared).
4. Overflow with evt_ready=0:
   - Send 17 frames 0x01..0x11 -> fifo_count=16, overflow=1.
   - Then evt_ready=1 -> pops 01..10 in order, 0x11 lost.
   - clr_flags -> overflow=0.
   - Then full FIFO with simultaneous push and pop -> count stays 16, no overflow.
5. Glitch and timeout:
   - 3-cycle low glitch on ps2_clk in IDLE -> ignored.
   - Start bit + 4 data bits then ps2_clk held high -> frame_err after 2000 cycles; next frame 0x29 decoded correctly.
6. Reset mid-stream: 3 events queued plus a half-received frame, pulse rst -> evt_valid=0, fifo_count=0 immediately; next frame 0x1C decoded normally.
